// File: rtl/core_sequencer.sv
// Instruction sequencer for the 2-bit state processor core: buffers {i1,i0} words and issues one per cycle.
// Latency: a head entry visible in RUN drives core_clk_en the same cycle; the core updates on the next edge.
// Backpressure: in_ready = !full, with no push into a full FIFO even when a pop happens in the same cycle.
//
// Ports: clk/rst_n (async active-low); start/stop/step_mode control the FSM;
// halt_en/halt_state/core_state select halt-on-match; in_valid/in_instr/in_ready form the push side;
// core_clk_en/core_i1/core_i0 drive the core; busy/halted/issue_cnt/fifo_level report status.
// Build option: define SEQ_FLUSH_ON_STOP_EN so that stop also empties the FIFO. A push in the same cycle is dropped.

// Small synchronous FIFO with a registered occupancy count.
// Latency: an entry pushed on one edge is visible at the head after that edge (no empty bypass).
// Backpressure: push_rdy = !full. Flush has priority over both push and pop.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    output logic                   push_rdy,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic                   head_vld,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_rdy = !full;
    assign head_vld = !empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    // The full check uses the current level only, so a same-cycle pop does not free a slot.
    assign do_push = push_vld && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: head_dat is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module core_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   step_mode,
    input  logic                   halt_en,
    input  logic [1:0]             halt_state,
    input  logic                   in_valid,
    input  logic [1:0]             in_instr,
    output logic                   in_ready,
    input  logic [1:0]             core_state,
    output logic                   core_clk_en,
    output logic                   core_i1,
    output logic                   core_i0,
    output logic                   busy,
    output logic                   halted,
    output logic [CNT_W-1:0]       issue_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     state;
    logic       issued_q;
    logic       halt_hit;
    logic       issue;
    logic       flush;
    logic [1:0] head_dat;
    logic       head_vld;

`ifdef SEQ_FLUSH_ON_STOP_EN
    assign flush = stop;
`else
    assign flush = 1'b0;
`endif

    seq_fifo #(
        .DEPTH (DEPTH),
        .W     (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push_vld (in_valid),
        .push_dat (in_instr),
        .push_rdy (in_ready),
        .pop      (issue),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .level    (fifo_level)
    );

    // A match only counts after an instruction has actually gone into the core.
    // issued_q is therefore clear on HALT entry, so a restart does not re-halt
    // immediately on the same stale core state.
    assign halt_hit = halt_en && issued_q && (core_state == halt_state);
    assign issue    = (state == S_RUN) && head_vld && !halt_hit && !stop;

    assign core_clk_en        = issue;
    assign {core_i1, core_i0} = head_dat;
    assign busy               = (state == S_RUN);
    assign halted             = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            issued_q  <= 1'b0;
            issue_cnt <= '0;
        end else begin
            issued_q <= issue;

            // The counter cannot clear and increment in the same cycle: no issue happens in IDLE.
            if (issue && (issue_cnt != {CNT_W{1'b1}}))
                issue_cnt <= issue_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (!stop && start) begin
                        state     <= S_RUN;
                        issue_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (stop)
                        state <= S_IDLE;
                    else if (halt_hit)
                        state <= S_HALT;
                    else if (step_mode && issue)
                        state <= S_IDLE;
                end
                S_HALT: begin
                    // Resuming keeps issue_cnt, so a halted run counts as one run.
                    if (stop)
                        state <= S_IDLE;
                    else if (start)
                        state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       step_mode;
    logic       halt_en;
    logic [1:0] halt_state;
    logic       in_valid;
    logic [1:0] in_instr;
    logic       in_ready;
    logic [1:0] core_state;
    logic       core_clk_en;
    logic       core_i1;
    logic       core_i0;
    logic       busy;
    logic       halted;
    logic [7:0] issue_cnt;
    logic [2:0] fifo_level;

    int n_assert = 0;
    int n_fail   = 0;

    core_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .step_mode   (step_mode),
        .halt_en     (halt_en),
        .halt_state  (halt_state),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .core_state  (core_state),
        .core_clk_en (core_clk_en),
        .core_i1     (core_i1),
        .core_i0     (core_i0),
        .busy        (busy),
        .halted      (halted),
        .issue_cnt   (issue_cnt),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drop the single-cycle pulses.
    task automatic nxt();
        @(negedge clk);
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [1:0] v);
        nxt();
        in_valid = 1'b1;
        in_instr = v;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        step_mode  = 1'b0;
        halt_en    = 1'b0;
        halt_state = 2'b00;
        in_valid   = 1'b0;
        in_instr   = 2'b00;
        core_state = 2'b00;
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_cnt", issue_cnt, 0);
        chk("rst_clken", core_clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_instr", {core_i1, core_i0}, 0);
        nxt();
        rst_n = 1'b1;

        // Continuous run: 01,10,11.
        push(2'b01); push(2'b10); push(2'b11);
        nxt(); #1;
        chk("run_level3", fifo_level, 3);
        chk("run_head", {core_i1, core_i0}, 2'b01);
        chk("run_idle_noissue", core_clk_en, 0);
        start = 1'b1; #1;
        chk("run_start_cycle", core_clk_en, 0);
        nxt(); #1;
        chk("run_en0", core_clk_en, 1); chk("run_i0", {core_i1, core_i0}, 2'b01);
        chk("run_busy", busy, 1); chk("run_cnt0", issue_cnt, 0);
        nxt(); #1;
        chk("run_en1", core_clk_en, 1); chk("run_i1", {core_i1, core_i0}, 2'b10);
        nxt(); #1;
        chk("run_en2", core_clk_en, 1); chk("run_i2", {core_i1, core_i0}, 2'b11);
        nxt(); #1;
        chk("run_starved", core_clk_en, 0); chk("run_cnt3", issue_cnt, 3);
        chk("run_level0", fifo_level, 0); chk("run_busy_starved", busy, 1);
        stop = 1'b1;
        nxt(); #1;
        chk("stop_busy", busy, 0);

        // Single step: 10 then 01.
        step_mode = 1'b1;
        push(2'b10); push(2'b01);
        nxt();
        start = 1'b1;
        nxt(); #1;
        chk("step1_en", core_clk_en, 1); chk("step1_i", {core_i1, core_i0}, 2'b10);
        nxt(); #1;
        chk("step1_idle", busy, 0); chk("step1_noen", core_clk_en, 0);
        chk("step1_cnt", issue_cnt, 1); chk("step1_level", fifo_level, 1);
        start = 1'b1;
        nxt(); #1;
        chk("step2_en", core_clk_en, 1); chk("step2_i", {core_i1, core_i0}, 2'b01);
        chk("step2_cnt_cleared", issue_cnt, 0);
        nxt(); #1;
        chk("step2_cnt", issue_cnt, 1); chk("step2_idle", busy, 0);
        step_mode = 1'b0;

        // Halt on core_state == 01.
        halt_en = 1'b1; halt_state = 2'b01;
        push(2'b00); push(2'b00); push(2'b00);
        nxt();
        start = 1'b1;
        nxt(); #1;
        chk("halt_first_en", core_clk_en, 1);
        nxt();
        core_state = 2'b01; #1;
        chk("halt_hit_noen", core_clk_en, 0); chk("halt_hit_level", fifo_level, 2);
        nxt(); #1;
        chk("halt_halted", halted, 1); chk("halt_notbusy", busy, 0);
        chk("halt_cnt1", issue_cnt, 1); chk("halt_level2", fifo_level, 2);
        core_state = 2'b10;
        start = 1'b1;
        nxt(); #1;
        chk("resume_en0", core_clk_en, 1); chk("resume_halted", halted, 0);
        nxt(); #1;
        chk("resume_en1", core_clk_en, 1);
        nxt(); #1;
        chk("resume_done", core_clk_en, 0); chk("resume_cnt3", issue_cnt, 3);
        chk("resume_level0", fifo_level, 0);
        halt_en = 1'b0; core_state = 2'b00;
        stop = 1'b1;

        // Full FIFO and pointer wrap: 11,10,01,00 then 01 wrapped.
        push(2'b11); push(2'b10); push(2'b01); push(2'b00);
        nxt(); #1;
        chk("full_ready", in_ready, 0); chk("full_level", fifo_level, 4);
        in_valid = 1'b1; in_instr = 2'b01;
        nxt(); #1;
        chk("full_drop5", fifo_level, 4);
        start = 1'b1; in_valid = 1'b1; in_instr = 2'b01;
        nxt(); #1;
        chk("wrap_en0", core_clk_en, 1); chk("wrap_i0", {core_i1, core_i0}, 2'b11);
        chk("wrap_ready_full", in_ready, 0);
        in_valid = 1'b1; in_instr = 2'b10;
        nxt(); #1;
        chk("wrap_level_nopush", fifo_level, 3); chk("wrap_ready", in_ready, 1);
        chk("wrap_i1", {core_i1, core_i0}, 2'b10);
        in_valid = 1'b1; in_instr = 2'b01;
        nxt(); #1;
        chk("wrap_i2", {core_i1, core_i0}, 2'b01); chk("wrap_level_push", fifo_level, 3);
        nxt(); #1;
        chk("wrap_i3", {core_i1, core_i0}, 2'b00);
        nxt(); #1;
        chk("wrap_i4", {core_i1, core_i0}, 2'b01); chk("wrap_en4", core_clk_en, 1);
        nxt(); #1;
        chk("wrap_empty", core_clk_en, 0); chk("wrap_cnt5", issue_cnt, 5);
        stop = 1'b1;

        // start and stop together in IDLE.
        push(2'b11);
        nxt();
        start = 1'b1; stop = 1'b1; #1;
        chk("ss_noen", core_clk_en, 0);
        nxt(); #1;
        chk("ss_idle", busy, 0); chk("ss_noen2", core_clk_en, 0);
`ifdef SEQ_FLUSH_ON_STOP_EN
        chk("ss_level", fifo_level, 0);
`else
        chk("ss_level", fifo_level, 1);
`endif
        // Drain whatever remains, then return to IDLE.
        start = 1'b1;
        nxt(); nxt(); #1;
        chk("drain_level", fifo_level, 0);
        stop = 1'b1;

        // Reset mid-run with two entries pending.
        push(2'b01); push(2'b10); push(2'b11);
        nxt();
        start = 1'b1;
        nxt(); #1;
        chk("mid_en", core_clk_en, 1);
        nxt(); #1;
        chk("mid_level2", fifo_level, 2); chk("mid_cnt1", issue_cnt, 1);
        rst_n = 1'b0; #1;
        chk("arst_en", core_clk_en, 0); chk("arst_level", fifo_level, 0);
        chk("arst_cnt", issue_cnt, 0); chk("arst_busy", busy, 0);
        nxt();
        rst_n = 1'b1;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
